// File: rtl/cmp_minmax_ctrl.sv
// cmp_minmax_ctrl: running min/max of a sample stream using one shared
// 8-bit magnitude comparator (cmp), time-multiplexed by the sequencer FSM.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   start, len          job launch (IDLE only) and sample count
//   in_valid, in_data   sample handshake input (unsigned 8-bit)
//   in_ready            sample accepted this cycle (decoded from state)
//   busy, done, empty   job status; done is a one-cycle pulse
//   min_out, max_out    result of the last job
//   min_idx, max_idx    first-occurrence positions (only with macro)
//
// Optional feature: define CMP_MINMAX_IDX_EN to add min_idx/max_idx.

module cmp (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gt,
    output logic       lt,
    output logic       eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

module cmp_minmax_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [7:0]       min_out,
`ifdef CMP_MINMAX_IDX_EN
    output logic [7:0]       max_out,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
`else
    output logic [7:0]       max_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CMP_MAX,
        S_CMP_MIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       smp_q, smp_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       max_q, max_d;
    logic             empty_q, empty_d;
`ifdef CMP_MINMAX_IDX_EN
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
`endif

    logic [7:0] cmp_b;
    logic       c_gt;
    logic       c_lt;
    logic       c_eq;

    // The single comparator always sees the held sample on a; b is the
    // running max in CMP_MAX and the running min in CMP_MIN.
    assign cmp_b = (state_q == S_CMP_MIN) ? min_q : max_q;

    cmp u_cmp (
        .a  (smp_q),
        .b  (cmp_b),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        smp_d     = smp_q;
        min_d     = min_q;
        max_d     = max_q;
        empty_d   = empty_q;
`ifdef CMP_MINMAX_IDX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        cnt_d   = '0;
                        empty_d = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        empty_d   = 1'b1;
                        min_d     = 8'hFF;
                        max_d     = 8'h00;
`ifdef CMP_MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                        state_d   = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    smp_d = in_data;
                    if (cnt_q == '0) begin
                        // First sample seeds both extremes directly.
                        min_d     = in_data;
                        max_d     = in_data;
`ifdef CMP_MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                        cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
                        if (len_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_CMP_MAX;
                    end
                end
            end
            S_CMP_MAX: begin
                // Strict compare: a tie keeps the earlier maximum.
                if (c_gt && !c_eq) begin
                    max_d     = smp_q;
`ifdef CMP_MINMAX_IDX_EN
                    max_idx_d = cnt_q;
`endif
                end
                state_d = S_CMP_MIN;
            end
            S_CMP_MIN: begin
                if (c_lt && !c_eq) begin
                    min_d     = smp_q;
`ifdef CMP_MINMAX_IDX_EN
                    min_idx_d = cnt_q;
`endif
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            smp_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            empty_q   <= 1'b0;
`ifdef CMP_MINMAX_IDX_EN
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
            min_q     <= min_d;
            max_q     <= max_d;
            empty_q   <= empty_d;
`ifdef CMP_MINMAX_IDX_EN
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    assign in_ready = (state_q == S_FETCH);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign empty    = empty_q;
    assign min_out  = min_q;
    assign max_out  = max_q;
`ifdef CMP_MINMAX_IDX_EN
    assign min_idx  = min_idx_q;
    assign max_idx  = max_idx_q;
`endif

endmodule
